// File: rtl/types_pkg.sv
// Shared types and constants for the fetch stage: the queued {pc, instr} pair
// and the queue depth the fetch unit is built around.
package types_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          FETCH_QDEPTH     = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_data;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} pairs with push, pop and a flush that
// empties it in one cycle; the head is always visible on o_head.
module fetch_queue
  import types_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_push,
  input  fetch_data i_pushData,
  input  logic      i_pop,
  input  logic      i_flush,
  output fetch_data o_head,
  output logic [1:0] o_count
);

  fetch_data  r_mem [FETCH_QDEPTH];
  logic       r_wrPtr;
  logic       r_rdPtr;
  logic [1:0] r_count;

  // Entries are cleared on reset so the head reads as zero while held in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wrPtr] <= i_pushData;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (i_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

  a_noOverflow : assert property (@(posedge clk) disable iff (reset)
    !(i_push && !i_pop && !i_flush && r_count == 2'd2));

  a_noUnderflow : assert property (@(posedge clk) disable iff (reset)
    !(i_pop && !i_flush && r_count == 2'd0));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential reads to a one-cycle memory,
// queues the returned words and hands them to decode with valid/ready.
module fetch_unit
  import types_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = FETCH_QDEPTH
)
(
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        valid_out,
  input  logic        ready_out,
  output logic [31:0] instr,
  output logic [31:0] pc_out
);

  logic [31:0] r_pc;
  logic [31:0] r_inflightPc;
  logic        r_inflight;

  logic [1:0]  w_count;
  fetch_data   w_head;
  fetch_data   w_pushData;
  logic        w_pop;
  logic        w_push;
  logic [2:0]  w_occupancy;

  assign valid_out = (w_count != 2'd0) && !redirect_valid;
  assign w_pop     = valid_out && ready_out;
  assign w_push    = r_inflight && !redirect_valid;

  // Queued plus in-flight words, less what leaves this cycle, must stay below
  // the queue depth so every response has a slot to land in.
  assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign imem_req    = !reset && !redirect_valid && (w_occupancy < 3'(QDEPTH));
  assign imem_addr   = r_pc;

  assign w_pushData.pc    = r_inflightPc;
  assign w_pushData.instr = imem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_inflight   <= 1'b0;
      r_inflightPc <= 32'd0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
    end else if (imem_req) begin
      r_pc         <= r_pc + 32'd4;
      r_inflight   <= 1'b1;
      r_inflightPc <= r_pc;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_pushData (w_pushData),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  assign instr  = w_head.instr;
  assign pc_out = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed latency/stall/redirect/reset
// scenarios plus a random ready/redirect run against a request-queue model.
module tb_fetch_unit;

  localparam logic [31:0] XOR_KEY = 32'hA5A5_A5A5;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        valid_out;
  logic        ready_out = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc_out;

  logic        wImemReq;
  logic [31:0] wImemAddr;
  logic [31:0] wImemRdata = 32'd0;
  logic        wValid;
  logic [31:0] wInstr;
  logic [31:0] wPcOut;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .valid_out      (valid_out),
    .ready_out      (ready_out),
    .instr          (instr),
    .pc_out         (pc_out)
  );

  fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (wImemReq),
    .imem_addr      (wImemAddr),
    .imem_rdata     (wImemRdata),
    .redirect_valid (1'b0),
    .redirect_pc    (32'd0),
    .valid_out      (wValid),
    .ready_out      (1'b1),
    .instr          (wInstr),
    .pc_out         (wPcOut)
  );

  // One-cycle instruction memories whose contents are a function of address.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ XOR_KEY;
    if (wImemReq) wImemRdata <= wImemAddr ^ XOR_KEY;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rpc);
    ready_out      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Model: every request still owed to decode, in issue order, tagged with the
  // cycle it was issued. A word is presentable two cycles after its request.
  typedef struct {
    int          issueCycle;
    logic [31:0] pc;
  } req_t;

  req_t        reqQ[$];
  logic [31:0] modelPc = 32'd0;
  int          cyc = 0;
  logic        expValid;
  logic        expPop;
  logic        expReq;

  always @(negedge clk) begin
    if (reset) begin
      checkOutput("rst_valid", {31'd0, valid_out}, 32'd0);
      checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
      checkOutput("rst_addr", imem_addr, 32'd0);
      checkOutput("rst_instr", instr, 32'd0);
      checkOutput("rst_pc", pc_out, 32'd0);
      reqQ.delete();
      modelPc = 32'd0;
      cyc = 0;
    end else begin
      expValid = !redirect_valid && reqQ.size() > 0 && reqQ[0].issueCycle <= cyc - 2;
      expPop   = expValid && ready_out;
      expReq   = !redirect_valid && (reqQ.size() - int'(expPop)) < 2;
      checkOutput("valid", {31'd0, valid_out}, {31'd0, expValid});
      checkOutput("req", {31'd0, imem_req}, {31'd0, expReq});
      checkOutput("addr", imem_addr, modelPc);
      if (expValid) begin
        checkOutput("pc_out", pc_out, reqQ[0].pc);
        checkOutput("instr", instr, reqQ[0].pc ^ XOR_KEY);
      end
      if (redirect_valid) begin
        reqQ.delete();
        modelPc = redirect_pc;
      end else begin
        if (expPop) void'(reqQ.pop_front());
        if (expReq) begin
          reqQ.push_back('{issueCycle: cyc, pc: modelPc});
          modelPc = modelPc + 32'd4;
        end
      end
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Latency and streaming from reset, plus the wrapping instance.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checkOutput("first_req", {31'd0, imem_req}, 32'd1);
        checkOutput("first_addr", imem_addr, 32'h0000_0000);
      end
      if (c == 1) checkOutput("c1_valid", {31'd0, valid_out}, 32'd0);
      if (c >= 2) begin
        checkOutput("stream_valid", {31'd0, valid_out}, 32'd1);
        checkOutput("stream_pc", pc_out, 32'(4 * (c - 2)));
        checkOutput("stream_instr", instr, 32'(4 * (c - 2)) ^ XOR_KEY);
      end
      if (c >= 2 && c <= 4) begin
        checkOutput("wrap_valid", {31'd0, wValid}, 32'd1);
        checkOutput("wrap_pc", wPcOut, WRAP_PC + 32'(4 * (c - 2)));
        checkOutput("wrap_instr", wInstr, (WRAP_PC + 32'(4 * (c - 2))) ^ XOR_KEY);
      end
      nextCycle();
    end

    // Stall with a full queue, then drain without gaps.
    doReset();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(c >= 7, 1'b0, 32'd0);
      @(negedge clk);
      if (c == 6) begin
        checkOutput("stall_valid", {31'd0, valid_out}, 32'd1);
        checkOutput("stall_pc", pc_out, 32'h0000_0000);
        checkOutput("stall_req", {31'd0, imem_req}, 32'd0);
      end
      if (c >= 7) begin
        checkOutput("drain_valid", {31'd0, valid_out}, 32'd1);
        checkOutput("drain_pc", pc_out, 32'(4 * (c - 7)));
      end
      nextCycle();
    end

    // Redirect while the queue is full.
    doReset();
    for (int c = 0; c < 8; c++) begin
      applyStimulus(c >= 4, c == 4, 32'h0000_0100);
      @(negedge clk);
      if (c == 4) checkOutput("redir_valid", {31'd0, valid_out}, 32'd0);
      if (c == 5) begin
        checkOutput("redir_req", {31'd0, imem_req}, 32'd1);
        checkOutput("redir_addr", imem_addr, 32'h0000_0100);
      end
      if (c == 6) checkOutput("redir_gap", {31'd0, valid_out}, 32'd0);
      if (c == 7) begin
        checkOutput("redir_dvalid", {31'd0, valid_out}, 32'd1);
        checkOutput("redir_pc", pc_out, 32'h0000_0100);
      end
      nextCycle();
    end

    // Asynchronous reset in the middle of a full stall.
    doReset();
    repeat (5) nextCycle();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_valid", {31'd0, valid_out}, 32'd0);
    checkOutput("async_req", {31'd0, imem_req}, 32'd0);
    checkOutput("async_addr", imem_addr, 32'h0000_0000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) begin
        checkOutput("restart_valid", {31'd0, valid_out}, 32'd1);
        checkOutput("restart_pc", pc_out, 32'h0000_0000);
      end
      nextCycle();
    end

    // Random backpressure and redirects, including targets near the wrap point.
    for (int i = 0; i < 800; i++) begin
      logic        rv;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      applyStimulus($urandom_range(0, 9) < 7, rv, rpc);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 32'd0);
    repeat (6) nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
